// File: rtl/multi_ch_log_capture.sv
// N-channel capture engine: selects one tap, waits for a trigger, decimates and
// stores sign-extended samples into an inferred block RAM that is read back word by word.
module multi_ch_log_capture #(
  parameter int NUM_CH    = 4,
  parameter int NBT_CH    = 16,
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 4096,
  parameter int NBT_DECIM = 8
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic [NUM_CH*NBT_CH-1:0]     i_ch_data,
  input  logic                         i_ch_valid,
  input  logic [$clog2(NUM_CH)-1:0]    i_ch_sel,
  input  logic [NBT_DECIM-1:0]         i_decim,
  input  logic [1:0]                   i_trig_mode,
  input  logic                         i_ext_trig,
  input  logic [NBT_CH-1:0]            i_threshold,
  input  logic                         i_arm,
  input  logic                         i_rd_en,
  input  logic [$clog2(RAM_DEPTH)-1:0] i_rd_adrs,
  output logic [RAM_WIDTH-1:0]         o_rd_data,
  output logic                         o_rd_valid,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [$clog2(RAM_DEPTH):0]   o_wr_count
);

  localparam int CW    = $clog2(NUM_CH);
  localparam int AW    = $clog2(RAM_DEPTH);
  localparam int CNT_W = AW + 1;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic [NBT_DECIM-1:0]      dcnt_q, dcnt_d;
  logic                      ext_prev_q;
  logic                      pend_q, pend_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [RAM_WIDTH-1:0]      rd_data_q;

  // Capture settings, only meaningful after an arm
  logic [CW-1:0]             ch_sel_q;
  logic [NBT_DECIM-1:0]      decim_q;
  logic [1:0]                mode_q;
  logic signed [NBT_CH-1:0]  thr_q;

  logic [RAM_WIDTH-1:0]      mem [RAM_DEPTH];

  logic signed [NBT_CH-1:0]  s;
  logic                      edge_now;
  logic                      trig;
  logic                      wr_en;
  logic [AW-1:0]             wr_addr;

  function automatic logic signed [RAM_WIDTH-1:0] sext(input logic signed [NBT_CH-1:0] x);
    return RAM_WIDTH'(x);
  endfunction

  always_comb begin
    s = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch_sel_q == CW'(k)) s = i_ch_data[k*NBT_CH +: NBT_CH];
  end

  assign edge_now = i_ext_trig & ~ext_prev_q;

  always_comb begin
    case (mode_q)
      2'b01:   trig = pend_q | edge_now;
      2'b10:   trig = (s >= thr_q);
      default: trig = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dcnt_d  = dcnt_q;
    pend_d  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    if (i_arm) begin
      // Arm wins over any trigger or write in the same cycle
      state_d = ARMED;
      count_d = '0;
      dcnt_d  = '0;
    end else begin
      case (state_q)
        ARMED: begin
          pend_d = pend_q | edge_now;
          if (i_ch_valid) begin
            pend_d = 1'b0;
            if (trig) begin
              wr_en   = 1'b1;
              count_d = CNT_W'(1);
              dcnt_d  = '0;
              state_d = (CNT_W'(1) == CNT_W'(RAM_DEPTH)) ? DONE : CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (i_ch_valid) begin
            if (dcnt_q == decim_q) begin
              dcnt_d  = '0;
              wr_en   = 1'b1;
              wr_addr = count_q[AW-1:0];
              count_d = count_q + 1'b1;
              if (count_d == CNT_W'(RAM_DEPTH)) state_d = DONE;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    busy_d     = (state_d == ARMED) || (state_d == CAPTURE);
    done_d     = (state_d == DONE);
    rd_valid_d = i_rd_en & ~busy_q;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      dcnt_q     <= '0;
      ext_prev_q <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      dcnt_q     <= dcnt_d;
      ext_prev_q <= i_ext_trig;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      if (rd_valid_d) rd_data_q <= mem[i_rd_adrs];
    end
  end

  always_ff @(posedge clk) begin
    if (i_arm) begin
      ch_sel_q <= i_ch_sel;
      decim_q  <= i_decim;
      mode_q   <= i_trig_mode;
      thr_q    <= i_threshold;
    end
  end

  // RAM contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en && !i_reset) mem[wr_addr] <= sext(s);
  end

  assign o_rd_data  = rd_data_q;
  assign o_rd_valid = rd_valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_wr_count = count_q;

endmodule

// File: tb/tb_multi_ch_log_capture.sv
// Directed bench for multi_ch_log_capture: trigger modes, decimation, abort, reset and readback.
module tb_multi_ch_log_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] ch_data;
  logic        valid;
  logic [1:0]  ch_sel;
  logic [7:0]  decim;
  logic [1:0]  trig_mode;
  logic        ext;
  logic [15:0] thr;
  logic        arm;
  logic        rd_en;
  logic [11:0] rd_adrs;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        done;
  logic [12:0] wr_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_ch_log_capture dut (
    .clk(clk), .i_reset(rst), .i_ch_data(ch_data), .i_ch_valid(valid),
    .i_ch_sel(ch_sel), .i_decim(decim), .i_trig_mode(trig_mode),
    .i_ext_trig(ext), .i_threshold(thr), .i_arm(arm), .i_rd_en(rd_en),
    .i_rd_adrs(rd_adrs), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_busy(busy), .o_done(done), .o_wr_count(wr_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cfg(input int sel, input int dec, input int mode, input int th);
    ch_sel = 2'(sel); decim = 8'(dec); trig_mode = 2'(mode); thr = 16'(th);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic push(input int ch, input int v);
    ch_data[ch*16 +: 16] = 16'(v);
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input int adr, input logic [31:0] exp);
    rd_en = 1'b1; rd_adrs = 12'(adr);
    tick();
    rd_en = 1'b0;
    chk({tag, "_vld"}, rd_valid, 1);
    chk(tag, rd_data, exp);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cnt"}, wr_count, 0);
    chk({tag, "_rdv"}, rd_valid, 0);
    chk({tag, "_rdd"}, rd_data, 0);
  endtask

  initial begin
    rst = 1'b1; ch_data = '0; valid = 0; ch_sel = 0; decim = 0; trig_mode = 0;
    ext = 0; thr = 0; arm = 0; rd_en = 0; rd_adrs = 0;
    tick(); tick();
    do_reset("rst0");

    // Immediate trigger, full-depth ramp on channel 2
    arm_cfg(2, 0, 0, 0);
    chk("t1_busy_armed", busy, 1);
    for (int v = 0; v < 4096; v++) begin
      push(2, v);
      if (v == 99) chk("t1_cnt100", wr_count, 100);
      if (v == 4094) chk("t1_busy_late", busy, 1);
    end
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_cnt", wr_count, 4096);
    push(2, 12345);
    chk("t1_cnt_hold", wr_count, 4096);
    rd_chk("t1_rd10", 10, 10);
    tick();
    chk("t1_rdv_drop", rd_valid, 0);
    chk("t1_rd_hold", rd_data, 10);
    rd_chk("t1_rd0", 0, 0);
    rd_chk("t1_rd4095", 4095, 4095);

    // Threshold trigger on channel 0, ramp from -50
    ch_data[2*16 +: 16] = 16'd7777;
    arm_cfg(0, 0, 2, 100);
    chk("t2_done_clr", done, 0);
    for (int v = -50; v < 110; v++) push(0, v);
    chk("t2_cnt", wr_count, 10);
    chk("t2_busy", busy, 1);
    do_reset("t2_rst");
    rd_chk("t2_rd0", 0, 100);
    rd_chk("t2_rd1", 1, 101);
    rd_chk("t2_rd9", 9, 109);
    rd_chk("t2_rd10", 10, 10);

    // Sign extension of negative samples
    arm_cfg(1, 0, 0, 0);
    push(1, -5);
    push(1, -6);
    chk("t3_cnt", wr_count, 2);
    do_reset("t3_rst");
    rd_chk("t3_rd0", 0, 32'hFFFF_FFFB);
    rd_chk("t3_rd1", 1, 32'hFFFF_FFFA);

    // Decimation by 4 with idle gaps between strobes
    arm_cfg(3, 3, 0, 0);
    for (int v = 0; v < 40; v++) begin
      push(3, v);
      tick();
    end
    chk("t4_cnt", wr_count, 10);
    do_reset("t4_rst");
    rd_chk("t4_rd1", 1, 4);
    rd_chk("t4_rd2", 2, 8);
    rd_chk("t4_rd9", 9, 36);
    rd_chk("t4_rd10", 10, 10);

    // External edge between valid strobes
    ext = 1'b0;
    arm_cfg(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) push(0, 500 + i);
    chk("t5_cnt_wait", wr_count, 0);
    chk("t5_busy_wait", busy, 1);
    ext = 1'b1;
    tick();
    tick();
    push(0, 777);
    chk("t5_cnt1", wr_count, 1);
    push(0, 778);
    chk("t5_cnt2", wr_count, 2);
    ext = 1'b0;
    do_reset("t5_rst");
    rd_chk("t5_rd0", 0, 777);
    rd_chk("t5_rd1", 1, 778);

    // Abort at count 37, re-arm takes priority over the pending write
    arm_cfg(0, 0, 0, 0);
    for (int v = 0; v < 37; v++) push(0, v);
    chk("t6_cnt37", wr_count, 37);
    ch_data[15:0] = 16'd9999;
    valid = 1'b1; arm = 1'b1;
    tick();
    valid = 1'b0; arm = 1'b0;
    chk("t6_cnt_clr", wr_count, 0);
    chk("t6_busy", busy, 1);
    push(0, 2000);
    push(0, 2001);
    chk("t6_cnt2", wr_count, 2);
    rd_en = 1'b1; rd_adrs = 12'd5;
    tick();
    rd_en = 1'b0;
    chk("t6_rd_busy_vld", rd_valid, 0);
    chk("t6_rd_busy_hold", rd_data, 778);
    do_reset("t6_rst");
    rd_chk("t6_rd0", 0, 2000);
    rd_chk("t6_rd1", 1, 2001);
    rd_chk("t6_rd2", 2, 2);
    rd_chk("t6_rd37", 37, 37);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
